// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the hazard scoreboard: opcode constants, opcode
// classification helpers and the counter-width derivation.
package hazard_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    // Branches resolve in ID, so they cannot use EX forwarding.
    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return op == OP_J;
    endfunction

    // The counter must be able to hold the longest producer latency.
    function automatic int cnt_width(input int load_lat);
        return $clog2(load_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage interface of the hazard scoreboard. Decode drives the master side.
// The scoreboard implements the slave side.
interface hazard_scoreboard_unit_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
);
    logic              id_valid;
    logic [5:0]        id_op;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_reg;
    logic              id_is_load;
    logic              id_branch_taken;
    logic              ext_flush;

    logic                stall;
    logic                flush_idex;
    logic                flush_ifid;
    logic [NUM_REGS-1:0] busy_mask;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load, id_branch_taken, ext_flush,
        input  stall, flush_idex, flush_ifid, busy_mask
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wr_en, id_wr_reg, id_is_load, id_branch_taken, ext_flush,
        output stall, flush_idex, flush_ifid, busy_mask
    );
endinterface

// File: rtl/hazard_scoreboard_unit_reg_busy_counter.sv
// Remaining-latency counter for one architectural register. A load from the
// issuing instruction takes precedence over the per-cycle decrement. The
// counter stops at zero.
module reg_busy_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          busy_next
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on issue, otherwise count down towards zero.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_en) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so that every flop samples pre-edge values.
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt       = cnt_q;
    assign busy_next = (cnt_d != '0);
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Countdown-scoreboard hazard unit for the ID stage. The unit produces stall,
// flush_idex and flush_ifid from the registered counts and the current ID
// inputs.
// Optional macro HAZARD_STATS_EN adds the stall_cycles and flush_count
// statistics outputs.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int EX_FWD   = 1
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    localparam int            CW        = cnt_width(LOAD_LAT);
    localparam logic [CW-1:0] ALU_VAL   = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_VAL  = CW'(LOAD_LAT);
    localparam logic [CW-1:0] EX_FWD_CW = CW'(EX_FWD);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic                busy_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy_mask_q;
    logic [NUM_REGS-1:0] busy_mask_d;

    logic          br;
    logic          jmp;
    logic [CW-1:0] thr;
    logic          haz_rs;
    logic          haz_rt;
    logic          stall_c;
    logic          issue;
    logic [CW-1:0] load_val;

    // Hazard detection and pipeline control from the pre-update counts.
    always_comb begin
        br  = is_branch(bus.id_op);
        jmp = is_jump(bus.id_op);
        // A branch compares in ID and needs a ready operand. Other consumers
        // can pick up a result that is EX_FWD cycles away by forwarding.
        thr    = br ? '0 : EX_FWD_CW;
        haz_rs = bus.id_use_rs && (bus.id_rs != '0) && (cnt[bus.id_rs] > thr);
        haz_rt = bus.id_use_rt && (bus.id_rt != '0) && (cnt[bus.id_rt] > thr);

        stall_c  = bus.id_valid && !bus.ext_flush && (haz_rs || haz_rt);
        issue    = bus.id_valid && !stall_c && !bus.ext_flush;
        load_val = bus.id_is_load ? LOAD_VAL : ALU_VAL;

        bus.stall      = stall_c;
        bus.flush_idex = stall_c || bus.ext_flush;
        bus.flush_ifid = (bus.id_valid && !stall_c &&
                          ((br && bus.id_branch_taken) || jmp)) || bus.ext_flush;
    end

    // Register 0 is hardwired zero, so it is never tracked.
    assign cnt[0]       = '0;
    assign busy_next[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        reg_busy_counter #(.CW(CW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .load_en   (issue && bus.id_wr_en && (bus.id_wr_reg == REG_AW'(r))),
            .load_val  (load_val),
            .cnt       (cnt[r]),
            .busy_next (busy_next[r])
        );
    end

    // Gather the post-update busy bits for the registered mask.
    always_comb begin
        busy_mask_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_mask_d[i] = busy_next[i];
        end
    end

    // Busy mask register reflects the counts after this cycle's update.
    always_ff @(posedge clk) begin
        if (rst) busy_mask_q <= '0;
        else     busy_mask_q <= busy_mask_d;
    end

    assign bus.busy_mask = busy_mask_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    // Event counters advance on each stalled and each IF/ID-flushed cycle.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_c)        stall_cycles_d = stall_cycles_q + 32'd1;
        if (bus.flush_ifid) flush_count_d  = flush_count_q + 32'd1;
    end

    // Statistics registers are cleared by reset and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed testbench for hazard_scoreboard_unit. The bench drives inputs
// 1 ns after the rising edge. It checks the combinational outputs 1 ns after
// that, well before the next edge.
module tb_hazard_scoreboard_unit;
    import hazard_pkg::*;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_scoreboard_unit_if #(.NUM_REGS(32), .REG_AW(5)) bus ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    hazard_scoreboard_unit #(
        .NUM_REGS(32), .REG_AW(5), .ALU_LAT(1), .LOAD_LAT(2), .EX_FWD(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt,
                         input logic we, input logic [4:0] wr,
                         input logic ld, input logic tk);
        bus.id_valid        = v;
        bus.id_op           = op;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_use_rs       = urs;
        bus.id_use_rt       = urt;
        bus.id_wr_en        = we;
        bus.id_wr_reg       = wr;
        bus.id_is_load      = ld;
        bus.id_branch_taken = tk;
        bus.ext_flush       = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_busy: got %h want 00000000", bus.busy_mask);
        end
    endtask

    task automatic test_load_use();
        // lw $8, 0($1)
        drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        n_checks++;
        if (bus.busy_mask !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL lu_busy8: got %h want 00000100", bus.busy_mask);
        end
        // add $11, $8, $2: first cycle stalls with cnt[8]=2
        drive(1'b1, OP_ADD, 5'd8, 5'd2, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b110) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 110", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        // cnt[8]=1 is within forwarding reach: issue
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b000) begin
            n_fail++;
            $display("FAIL lu_issue: got %b want 000", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        n_checks++;
        if (bus.busy_mask !== 32'h0000_0800) begin
            n_fail++;
            $display("FAIL lu_busy11: got %h want 00000800", bus.busy_mask);
        end
        idle(3);
    endtask

    task automatic test_alu_branch();
        // add $9
        drive(1'b1, OP_ADD, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        step();
        // beq $9, $0, taken: stall wins over the flush
        drive(1'b1, OP_BEQ, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b110) begin
            n_fail++;
            $display("FAIL ab_stall: got %b want 110", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b001) begin
            n_fail++;
            $display("FAIL ab_flush: got %b want 001", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        idle(3);
    endtask

    task automatic test_load_branch();
        // lw $10
        drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0);
        step();
        // bne $10, $3, taken: two stall cycles
        drive(1'b1, OP_BNE, 5'd10, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b110) begin
            n_fail++;
            $display("FAIL lb_stall1: got %b want 110", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b110) begin
            n_fail++;
            $display("FAIL lb_stall2: got %b want 110", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b001) begin
            n_fail++;
            $display("FAIL lb_flush: got %b want 001", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        idle(3);
    endtask

    task automatic test_zero_unused();
        // lw $0 is never tracked
        drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        step();
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL zu_busy0: got %h want 00000000", bus.busy_mask);
        end
        // lw $13, 0($0)
        drive(1'b1, OP_LW, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b000) begin
            n_fail++;
            $display("FAIL zu_zero_src: got %b want 000", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        // add $12, $0, rt=$13 not read
        drive(1'b1, OP_ADD, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b000) begin
            n_fail++;
            $display("FAIL zu_unused_rt: got %b want 000", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        n_checks++;
        if (bus.busy_mask !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL zu_busy: got %h want 00003000", bus.busy_mask);
        end
        idle(3);
    endtask

    task automatic test_jump_ext_flush();
        // invalid jump does nothing
        drive(1'b0, OP_J, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b000) begin
            n_fail++;
            $display("FAIL je_jump_invalid: got %b want 000", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        drive(1'b1, OP_J, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b001) begin
            n_fail++;
            $display("FAIL je_jump: got %b want 001", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        // lw $8, then add $14, $8 under ext_flush
        drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_ADD, 5'd8, 5'd2, 1'b1, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0);
        bus.ext_flush = 1'b1;
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b011) begin
            n_fail++;
            $display("FAIL je_ext_flush: got %b want 011", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        step();
        n_checks++;
        if (bus.busy_mask !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL je_no_issue: got %h want 00000100", bus.busy_mask);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_stall();
        // lw $8, then add using $8 with reset on the stall cycle
        drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        step();
        drive(1'b1, OP_ADD, 5'd8, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rm_stall: got %b want 000", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_busy: got %h want 00000000", bus.busy_mask);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        // lw $5 twice: the second issue reloads cnt[5] to 2
        drive(1'b1, OP_LW, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
        step();
        #1;
        step();
        drive(1'b1, OP_ADD, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.stall, bus.flush_idex, bus.flush_ifid} !== 3'b110) begin
            n_fail++;
            $display("FAIL bb_reload_stall: got %b want 110", {bus.stall, bus.flush_idex, bus.flush_ifid});
        end
        idle(1);
        n_checks++;
        if (bus.busy_mask !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL bb_busy1: got %h want 00000020", bus.busy_mask);
        end
        step();
        n_checks++;
        if (bus.busy_mask !== 32'h0) begin
            n_fail++;
            $display("FAIL bb_busy0: got %h want 00000000", bus.busy_mask);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, OP_ADD, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_alu_branch();
        test_load_branch();
        test_zero_unused();
        test_jump_ext_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the pipeline hazard detector.
- Tracks in-flight register writes with a per-register countdown scoreboard instead of fixed stage comparisons.
- Produces stall, flush_idex and flush_ifid for the ID stage, with configurable producer latencies and forwarding slack.
- Sits between decode and the IF/ID, ID/EX pipeline registers; one scoreboard serves all consumers.

Parameters:
- NUM_REGS, 32: architectural registers; register 0 is hardwired zero and never tracked.
- REG_AW, 5: register index width, equal to clog2(NUM_REGS).
- ALU_LAT, 1: cycles after issue until an ALU result is visible to the ID stage.
- LOAD_LAT, 2: cycles after issue until load data is visible to the ID stage. Must be >= ALU_LAT.
- EX_FWD, 1: maximum remaining count an EX-stage consumer tolerates through forwarding.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  6  opcode in ID
- id_rs, id_rt  in  REG_AW  source registers
- id_use_rs, id_use_rt  in  1  source actually read
- id_wr_en  in  1  instruction writes a register
- id_wr_reg  in  REG_AW  destination register
- id_is_load  in  1  instruction is a load
- id_branch_taken  in  1  ID branch comparator result
- ext_flush  in  1  redirect from a later stage; kills ID
- stall  out  1  hold PC and IF/ID
- flush_idex  out  1  insert bubble into ID/EX
- flush_ifid  out  1  squash IF/ID
- busy_mask  out  NUM_REGS  registered; bit r = cnt[r] != 0

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State: cnt[r], width CW = clog2(LOAD_LAT+1), for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- Reset: all cnt = 0 and busy_mask = 0. With the scoreboard clear, stall = flush_idex = flush_ifid = 0. A reset asserted mid-operation clears everything in that cycle; no pending stall survives it.
- Branch: id_op is 000100 or 000101. Jump: id_op is 000010.
- Hazard on a used source s (s != 0):
  - branch consumer: hazard when cnt[s] > 0;
  - any other consumer: hazard when cnt[s] > EX_FWD.
- stall = id_valid & !ext_flush & (hazard on rs or rt). flush_idex = stall | ext_flush.
- flush_ifid = id_valid & !stall & ((branch & id_branch_taken) | jump), or ext_flush.
- Stall has priority: a branch waiting on an operand never flushes IF/ID until its operand is ready.
- Issue: issue = id_valid & !stall & !ext_flush.
- Per cycle, for each r:
  - if issue & id_wr_en & id_wr_reg == r & r != 0: cnt[r] <= (id_is_load ? LOAD_LAT : ALU_LAT). Issue wins over decrement.
  - else if cnt[r] != 0: cnt[r] <= cnt[r] - 1.
- Hazard checks use pre-update cnt. An instruction whose destination equals its own source does not stall itself.
- Outputs stall/flush_* are combinational from registered cnt and current ID inputs. They have zero-cycle latency and no registered delay.
- busy_mask is registered and reflects cnt after update.
- id_valid = 0: no stall, no flush_ifid, no issue; counters keep decrementing.
- Counters saturate at 0 and never wrap.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments each cycle stall = 1.
  - flush_count increments each cycle flush_ifid = 1.
  - Both cleared by rst and wrap at 2^32.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - opcode constants OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  - functions is_branch(op) and is_jump(op);
  - CW derivation.
- Sub-module reg_busy_counter: one CW-bit load/decrement counter per tracked register, instantiated by generate for r = 1..NUM_REGS-1.

Test Plan:
- Load-use: issue lw to $8 (cnt=2), next add using $8 -> stall=1, flush_idex=1 for exactly 1 cycle, then issue.
- ALU then branch: add $9, then beq $9,$0 -> stall 1 cycle. Next cycle id_branch_taken=1 -> flush_ifid=1, stall=0.
- Load then branch: lw $10, then bne $10,$3 -> stall 2 cycles, then flush_ifid follows id_branch_taken.
- $0 and unused sources: lw to $0, then add using $0; also id_use_rt=0 with id_rt matching a busy register -> stall=0, busy_mask[0]=0.
- Jump and ext_flush: jump with id_valid=1 -> flush_ifid=1. ext_flush=1 during a load-use hazard -> stall=0, flush_idex=1, flush_ifid=1, no issue.
- Reset mid-stall: lw $8, rst=1 on the stall cycle -> next cycle busy_mask = 0, stall = 0. Reissue lw $5 then lw $5 again -> cnt[5] reloads to 2 (issue beats decrement).
